// File: rtl/lcd_bus_reader.sv
// rtl/lcd_bus_reader.sv - timed HD44780 read-cycle controller with optional busy-flag polling
module lcd_bus_reader #(
    parameter int T_SETUP   = 4,
    parameter int T_EN_HIGH = 25,
    parameter int T_HOLD    = 4,
    parameter int T_RECOVER = 50,
    parameter int POLL_MAX  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       ready,
    output logic       done,
    output logic       timeout,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    input  logic [7:0] lcd_db_in,
    output logic       lcd_db_oe,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);
    localparam int M1   = (T_SETUP > T_EN_HIGH) ? T_SETUP : T_EN_HIGH;
    localparam int M2   = (T_HOLD > T_RECOVER) ? T_HOLD : T_RECOVER;
    localparam int MAXT = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXT + 1);
    localparam int PW   = $clog2(POLL_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HIGH,
        S_HOLD,
        S_RECOVER
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pcnt_q;
    logic          rs_q, rs_d;
    logic          poll_q;
    logic [7:0]    d_q;
    logic [7:0]    rd_data_q;
    logic          bf_q, timeout_q, done_q;
    logic [6:0]    ac_q;
    logic          en_q, rw_q, rsout_q, oe_q;
    logic          last, follow, accept, drive_d;

    assign last   = (cnt_q == '0);
    assign follow = poll_q && d_q[7] && (pcnt_q < PW'(POLL_MAX));
    assign accept = (state_q == S_IDLE) && req;
    assign rs_d   = accept ? (req_poll ? 1'b0 : req_rs) : rs_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_SETUP;
                    cnt_d   = CW'(T_SETUP - 1);
                end
            end
            S_SETUP: begin
                if (last) begin
                    state_d = S_EN_HIGH;
                    cnt_d   = CW'(T_EN_HIGH - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EN_HIGH: begin
                if (last) begin
                    state_d = S_HOLD;
                    cnt_d   = CW'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (last) begin
                    state_d = S_RECOVER;
                    cnt_d   = CW'(T_RECOVER - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RECOVER: begin
                if (last) begin
                    state_d = follow ? S_SETUP : S_IDLE;
                    cnt_d   = follow ? CW'(T_SETUP - 1) : '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus stays claimed through RECOVER when a further poll read is already known to follow
    assign drive_d = (state_d == S_SETUP) || (state_d == S_EN_HIGH) || (state_d == S_HOLD) ||
                     ((state_d == S_RECOVER) && follow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q      <= 1'b0;
            poll_q    <= 1'b0;
            pcnt_q    <= '0;
            d_q       <= 8'h00;
            rd_data_q <= 8'h00;
            bf_q      <= 1'b1;
            ac_q      <= 7'h00;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
            en_q      <= 1'b0;
            rw_q      <= 1'b0;
            rsout_q   <= 1'b0;
            oe_q      <= 1'b1;
        end else begin
            rs_q <= rs_d;
            if (accept) begin
                poll_q    <= req_poll;
                timeout_q <= 1'b0;
                pcnt_q    <= PW'(1);
            end
            // Sample on the edge that ends EN_HIGH; results appear from the first HOLD cycle
            if ((state_q == S_EN_HIGH) && last) begin
                d_q       <= lcd_db_in;
                rd_data_q <= lcd_db_in;
                if (!rs_q) begin
                    bf_q <= lcd_db_in[7];
                    ac_q <= lcd_db_in[6:0];
                end
            end
            if ((state_q == S_RECOVER) && last) begin
                if (follow) begin
                    pcnt_q <= pcnt_q + 1'b1;
                end else if (poll_q && d_q[7]) begin
                    timeout_q <= 1'b1;
                end
            end
            done_q  <= (state_q == S_RECOVER) && last && !follow;
            en_q    <= (state_d == S_EN_HIGH);
            rw_q    <= drive_d;
            rsout_q <= drive_d && rs_d;
            oe_q    <= !drive_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign rd_data   = rd_data_q;
    assign busy_flag = bf_q;
    assign addr_cnt  = ac_q;
    assign lcd_db_oe = oe_q;
    assign lcd_rs    = rsout_q;
    assign lcd_rw    = rw_q;
    assign lcd_en    = en_q;
endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb/tb_lcd_bus_reader.sv - directed self-checking bench for lcd_bus_reader
module tb_lcd_bus_reader;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req, req_rs, req_poll;
    logic       ready, done, timeout;
    logic [7:0] rd_data;
    logic       busy_flag;
    logic [6:0] addr_cnt;
    logic [7:0] lcd_db_in;
    logic       lcd_db_oe, lcd_rs, lcd_rw, lcd_en;

    int checks = 0;
    int errors = 0;
    int pulses, en_cycles, done_cycle, done_count, rw_bad, rs_bad, falls, last_fall, first_rel;

    always #5 clk = ~clk;

    lcd_bus_reader #(.POLL_MAX(5)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_rs(req_rs), .req_poll(req_poll),
        .ready(ready), .done(done), .timeout(timeout), .rd_data(rd_data),
        .busy_flag(busy_flag), .addr_cnt(addr_cnt), .lcd_db_in(lcd_db_in),
        .lcd_db_oe(lcd_db_oe), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and watch the bus until a few cycles past done (bounded).
    task automatic run_req(input logic rs, input logic poll, input logic [7:0] bus_a,
                           input logic [7:0] bus_b, input int sw, input int repulse_at);
        logic en_prev;
        pulses = 0; en_cycles = 0; done_cycle = 0; done_count = 0; rw_bad = 0; rs_bad = 0;
        falls = 0; last_fall = 0; first_rel = 0; en_prev = 1'b0;
        lcd_db_in = bus_a; req_rs = rs; req_poll = poll; req = 1'b1;
        chk("ready_before_accept", ready, 1);
        for (int n = 1; n <= 1000; n++) begin
            @(posedge clk); #1;
            req = (n == repulse_at);
            if (lcd_en) en_cycles++;
            if (lcd_en && !en_prev) pulses++;
            if (!lcd_en && en_prev) begin
                falls++;
                last_fall = n;
                if (falls == sw) lcd_db_in = bus_b;
            end
            if (pulses > 0 && lcd_db_oe && first_rel == 0) first_rel = n;
            if (n <= 33 && lcd_rw !== 1'b1) rw_bad++;
            if (n <= 33 && lcd_rs !== rs) rs_bad++;
            if (done) begin
                done_count++;
                if (done_cycle == 0) done_cycle = n;
            end
            en_prev = lcd_en;
            if (done_cycle != 0 && n >= done_cycle + 3) break;
        end
        req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req_rs = 1'b0; req_poll = 1'b0; lcd_db_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_busy", busy_flag, 1);
        chk("rst_addr", addr_cnt, 7'h00);
        chk("rst_en", lcd_en, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("rst_oe", lcd_db_oe, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // RS=0 single read
        run_req(1'b0, 1'b0, 8'h25, 8'h25, 99, 0);
        chk("t1_rd_data", rd_data, 8'h25);
        chk("t1_busy", busy_flag, 0);
        chk("t1_addr", addr_cnt, 7'h25);
        chk("t1_en_cycles", en_cycles, 25);
        chk("t1_pulses", pulses, 1);
        chk("t1_rw_through_hold", rw_bad, 0);
        chk("t1_rs_low", rs_bad, 0);
        chk("t1_done_cycle", done_cycle, 84);
        chk("t1_done_count", done_count, 1);
        chk("t1_oe_release", first_rel, 34);
        chk("t1_idle_rw", lcd_rw, 0);

        // RS=1 data read leaves BF/AC alone
        run_req(1'b1, 1'b0, 8'hA5, 8'hA5, 99, 0);
        chk("t2_rd_data", rd_data, 8'hA5);
        chk("t2_rs_high", rs_bad, 0);
        chk("t2_busy_kept", busy_flag, 0);
        chk("t2_addr_kept", addr_cnt, 7'h25);
        chk("t2_done_cycle", done_cycle, 84);

        // Poll: busy for three reads, then clear
        run_req(1'b0, 1'b1, 8'h80, 8'h07, 3, 0);
        chk("t3_pulses", pulses, 4);
        chk("t3_done_cycle", done_cycle, 333);
        chk("t3_done_count", done_count, 1);
        chk("t3_timeout", timeout, 0);
        chk("t3_addr", addr_cnt, 7'h07);
        chk("t3_busy", busy_flag, 0);
        chk("t3_oe_held_between", first_rel, last_fall + 4);

        // Poll timeout at POLL_MAX=5
        run_req(1'b0, 1'b1, 8'hFF, 8'hFF, 99, 0);
        chk("t4_pulses", pulses, 5);
        chk("t4_done_cycle", done_cycle, 416);
        chk("t4_done_count", done_count, 1);
        chk("t4_timeout", timeout, 1);
        chk("t4_busy", busy_flag, 1);

        // Ignored req during SETUP; bus change after sample edge has no effect
        run_req(1'b0, 1'b0, 8'h11, 8'h22, 1, 2);
        chk("t5_pulses", pulses, 1);
        chk("t5_done_count", done_count, 1);
        chk("t5_rd_data", rd_data, 8'h11);
        chk("t5_addr", addr_cnt, 7'h11);
        chk("t5_timeout_cleared", timeout, 0);
        chk("t5_ready_after", ready, 1);

        // Asynchronous reset during EN_HIGH
        req_rs = 1'b0; req_poll = 1'b0; lcd_db_in = 8'h3C; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("t6_en_before_reset", lcd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_en", lcd_en, 0);
        chk("t6_oe", lcd_db_oe, 1);
        chk("t6_ready", ready, 1);
        chk("t6_rd_data", rd_data, 8'h00);
        chk("t6_busy", busy_flag, 1);
        chk("t6_addr", addr_cnt, 7'h00);
        @(posedge clk); #2;
        rst_n = 1'b1;
        done_count = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (done) done_count++;
        end
        chk("t6_no_done", done_count, 0);
        chk("t6_ready_after", ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_bus_reader.md
Name: lcd_bus_reader

Overview:
- Read-side controller for the 8-bit HD44780-style 16x2 LCD bus. It is the counterpart to the existing write-only LCD sequencer, which ties RW low.
- Executes timed read cycles (RW=1): busy-flag/address-counter reads (RS=0) and DDRAM/CGRAM data reads (RS=1).
- Optional autonomous busy-poll mode, so the writer can wait on BF instead of fixed delays.
- Sits beside the writer on the shared LCD pins; the top level muxes RS/RW/EN and uses lcd_db_oe to control the data-bus tristate.

Parameters:
T_SETUP, 4, clocks RS/RW stable before EN rises (min 1)
T_EN_HIGH, 25, clocks EN held high (min 1)
T_HOLD, 4, clocks RS/RW held after EN falls (min 1)
T_RECOVER, 50, clocks between EN fall+hold and next cycle/idle (min 1)
POLL_MAX, 1000, max read cycles in one poll request (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  1  start request, accepted when ready=1
req_rs  in  1  0 = read BF/AC, 1 = read data RAM
req_poll  in  1  1 = repeat BF reads until BF=0 (forces RS=0)
ready  out  1  idle, able to accept req
done  out  1  one-cycle pulse, request complete
timeout  out  1  poll ended with BF still 1
rd_data  out  8  last sampled bus byte
busy_flag  out  1  last BF (bit 7 of an RS=0 read)
addr_cnt  out  7  last AC (bits 6:0 of an RS=0 read)
lcd_db_in  in  8  LCD data bus input
lcd_db_oe  out  1  1 = other side may drive bus, 0 = bus released for LCD
lcd_rs  out  1  LCD RS
lcd_rw  out  1  LCD RW
lcd_en  out  1  LCD EN

Behaviour:
- One clock: clk. Reset is asynchronous and active-low (rst_n).
- Reset values (applied immediately on rst_n low, including mid-operation):
  - state IDLE, ready=1, done=0, timeout=0
  - rd_data=8'h00, busy_flag=1, addr_cnt=7'h00
  - lcd_en=0, lcd_rw=0, lcd_rs=0, lcd_db_oe=1
- States: IDLE -> SETUP -> EN_HIGH -> HOLD -> RECOVER -> (SETUP | IDLE). Each timed state lasts exactly its parameter count in clocks; the down-counter is wide enough for the largest parameter.
- Accept: req=1 and ready=1 in cycle 0.
  - Latch rs_q = req_poll ? 0 : req_rs, and latch poll_q = req_poll.
  - Clear timeout and reset the poll count to 1.
  - Enter SETUP in cycle 1; ready=0 from cycle 1.
  - req while ready=0 is ignored (no queueing).
- SETUP: lcd_rw=1, lcd_rs=rs_q, lcd_db_oe=0, lcd_en=0.
- EN_HIGH: lcd_en=1. lcd_db_in is sampled on the last EN_HIGH cycle into d_q. Bus changes after that edge have no effect.
- HOLD: lcd_en=0, RS/RW unchanged, lcd_db_oe=0.
- Result update, on HOLD entry:
  - rd_data<=d_q in all cases.
  - If rs_q=0, also busy_flag<=d_q[7] and addr_cnt<=d_q[6:0].
  - If rs_q=1, busy_flag and addr_cnt are unchanged.
- RECOVER: lcd_en=0.
  - If another read follows: RW=1, lcd_db_oe=0.
  - Else: RW=0, RS=0, lcd_db_oe=1 from RECOVER entry.
- Exit from RECOVER:
  - poll_q=1, d_q[7]=1, poll count < POLL_MAX: increment count, go to SETUP.
  - poll_q=1, d_q[7]=1, count = POLL_MAX: go to IDLE, timeout=1 (held until next accept).
  - Otherwise: go to IDLE.
- done=1 and ready=1 in the first IDLE cycle.
  - Single-read latency from accept: 1+T_SETUP+T_EN_HIGH+T_HOLD+T_RECOVER clocks (84 with defaults).
  - A new req may be accepted in that same cycle.
- Poll request with first read BF=0: exactly one cycle, identical to a single RS=0 read.
- lcd_en is a registered output with no glitches. EN never rises unless RW=1 and lcd_db_oe=0 have held for ≥T_SETUP clocks.

Test Plan:
- RS=0 read, lcd_db_in=8'h25 during EN -> rd_data=8'h25, busy_flag=0, addr_cnt=7'h25; lcd_en high exactly 25 clocks; lcd_rw=1 from cycle 1 through HOLD; done pulses once at cycle 84.
- RS=1 read after the previous test, lcd_db_in=8'hA5 -> rd_data=8'hA5, lcd_rs=1 during SETUP..HOLD, busy_flag=0 and addr_cnt=7'h25 unchanged.
- Poll, bus=8'h80 for the first 3 EN pulses then 8'h07 -> 4 EN pulses, RW stays 1 and lcd_db_oe stays 0 between them, single done, timeout=0, addr_cnt=7'h07.
- POLL_MAX=5, bus=8'hFF constant with req_poll=1 -> exactly 5 EN pulses, done with timeout=1, busy_flag=1; next accepted req clears timeout.
- rst_n low during EN_HIGH -> lcd_en=0, lcd_db_oe=1, ready=1 asynchronously; no done pulse; results return to reset values.
- req pulsed during SETUP of an active read -> ignored, only one EN pulse. Bus changed from 8'h11 to 8'h22 the cycle after the sample edge -> rd_data=8'h11.
